// File: rtl/bcd_step_counter.sv
// bcd_step_counter: two-digit BCD up/down counter with press-and-hold auto-repeat
// and an optional free-running upward count.
module bcd_step_counter #(
    parameter int MAX_COUNT     = 99,
    parameter int HOLD_CYCLES   = 12500000,
    parameter int REPEAT_CYCLES = 2500000,
    parameter int AUTO_CYCLES   = 500000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Up,
    input  logic       i_Down,
    input  logic       i_Auto_En,
    output logic [3:0] o_Tens,
    output logic [3:0] o_Ones,
    output logic       o_Toggle,
    output logic       o_Wrap
);
    localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int PW = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;
    localparam logic [TW-1:0] HOLD_END = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] RPT_END = TW'(REPEAT_CYCLES - 1);
    localparam logic [PW-1:0] AUTO_END = PW'(AUTO_CYCLES - 1);
    localparam logic [3:0] MAX_TENS = 4'(MAX_COUNT / 10);
    localparam logic [3:0] MAX_ONES = 4'(MAX_COUNT % 10);

    typedef enum logic [2:0] {IDLE, UP_HOLD, UP_RPT, DN_HOLD, DN_RPT} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d, timer_end;
    logic [PW-1:0] psc_q, psc_d;
    logic [3:0]    tens_q, tens_d, ones_q, ones_d;
    logic          toggle_q, toggle_d, wrap_q, wrap_d;
    logic          up_prev_q, up_prev_d, down_prev_q, down_prev_d;
    logic          up_press, dn_press, man_inc, man_dec, man_step, auto_tick, inc, at_max, at_zero;

    assign up_press  = i_Up && !up_prev_q;
    assign dn_press  = i_Down && !down_prev_q;
    assign timer_end = (state_q == UP_HOLD || state_q == DN_HOLD) ? HOLD_END : RPT_END;

    always_comb begin
        state_d = state_q;
        timer_d = '0;
        man_inc = 1'b0;
        man_dec = 1'b0;
        case (state_q)
            IDLE: begin
                if (up_press && !i_Down) begin
                    man_inc = 1'b1;
                    state_d = UP_HOLD;
                end else if (dn_press && !i_Up) begin
                    man_dec = 1'b1;
                    state_d = DN_HOLD;
                end
            end
            UP_HOLD, UP_RPT: begin
                if (!i_Up || i_Down) begin
                    state_d = IDLE;
                end else if (timer_q == timer_end) begin
                    man_inc = 1'b1;
                    state_d = UP_RPT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DN_HOLD, DN_RPT: begin
                if (!i_Down || i_Up) begin
                    state_d = IDLE;
                end else if (timer_q == timer_end) begin
                    man_dec = 1'b1;
                    state_d = DN_RPT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A manual step pre-empts a coinciding auto tick and restarts the prescaler.
    assign man_step  = man_inc || man_dec;
    assign auto_tick = (state_q == IDLE) && i_Auto_En && (psc_q == AUTO_END) && !man_step;
    assign inc       = man_inc || auto_tick;
    assign at_max    = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);
    assign at_zero   = (tens_q == 4'd0) && (ones_q == 4'd0);

    always_comb begin
        psc_d = ((state_q == IDLE) && i_Auto_En && !man_step && (psc_q != AUTO_END)) ? psc_q + PW'(1) : '0;
        ones_d = inc ? ((at_max || ones_q == 4'd9) ? 4'd0 : ones_q + 4'd1)
               : man_dec ? (at_zero ? MAX_ONES : (ones_q == 4'd0) ? 4'd9 : ones_q - 4'd1)
               : ones_q;
        tens_d = inc ? (at_max ? 4'd0 : (ones_q == 4'd9) ? tens_q + 4'd1 : tens_q)
               : man_dec ? (at_zero ? MAX_TENS : (ones_q == 4'd0) ? tens_q - 4'd1 : tens_q)
               : tens_q;
        toggle_d    = toggle_q ^ man_step;
        wrap_d      = (inc && at_max) || (man_dec && at_zero);
        up_prev_d   = i_Up;
        down_prev_d = i_Down;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            psc_q       <= '0;
            tens_q      <= 4'd0;
            ones_q      <= 4'd0;
            toggle_q    <= 1'b0;
            wrap_q      <= 1'b0;
            up_prev_q   <= 1'b1;
            down_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            psc_q       <= psc_d;
            tens_q      <= tens_d;
            ones_q      <= ones_d;
            toggle_q    <= toggle_d;
            wrap_q      <= wrap_d;
            up_prev_q   <= up_prev_d;
            down_prev_q <= down_prev_d;
        end
    end

    assign o_Tens   = tens_q;
    assign o_Ones   = ones_q;
    assign o_Toggle = toggle_q;
    assign o_Wrap   = wrap_q;
endmodule
